// File: rtl/io_port_ctrl.sv
// External I/O port controller: input FIFO feeding the register-file IN port,
// and a valid/ready output holding register loaded from R3 on each OUT request.
module io_port_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ext_in_data,
  input  logic             ext_in_valid,
  output logic             ext_in_ready,
  input  logic             in_req,
  output logic [WIDTH-1:0] InD,
  output logic             InE,
  output logic             in_stall,
  input  logic [WIDTH-1:0] OutD,
  input  logic             out_req,
  output logic             out_stall,
  output logic [WIDTH-1:0] ext_out_data,
  output logic             ext_out_valid,
  input  logic             ext_out_ready,
  output logic [CW-1:0]    fifo_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] in_data_reg;
  logic             in_en_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;

  logic push;
  logic pop;
  logic capture_ok;

  assign ext_in_ready  = (count_reg != CW'(DEPTH));
  assign push          = ext_in_valid & ext_in_ready;
  assign pop           = in_req & (count_reg != '0);
  assign in_stall      = in_req & (count_reg == '0);
  assign capture_ok    = ~out_valid_reg | ext_out_ready;
  assign out_stall     = out_req & out_valid_reg & ~ext_out_ready;

  assign fifo_count    = count_reg;
  assign InD           = in_data_reg;
  assign InE           = in_en_reg;
  assign ext_out_data  = out_data_reg;
  assign ext_out_valid = out_valid_reg;

  // Storage is left uninitialised on reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= ext_in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      in_data_reg <= '0;
      in_en_reg   <= 1'b0;
    end else begin
      in_en_reg <= pop;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        in_data_reg <= mem[rd_ptr_reg];
        rd_ptr_reg  <= rd_ptr_reg + AW'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  // A handshake and a new request in the same cycle reload back-to-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else if (out_req && capture_ok) begin
      out_data_reg  <= OutD;
      out_valid_reg <= 1'b1;
    end else if (out_valid_reg && ext_out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed self-checking bench for io_port_ctrl with hand-computed expectations.
module tb_io_port_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ext_in_data;
  logic       ext_in_valid;
  logic       ext_in_ready;
  logic       in_req;
  logic [3:0] InD;
  logic       InE;
  logic       in_stall;
  logic [3:0] OutD;
  logic       out_req;
  logic       out_stall;
  logic [3:0] ext_out_data;
  logic       ext_out_valid;
  logic       ext_out_ready;
  logic [2:0] fifo_count;

  int n_vec = 0;
  int n_err = 0;

  io_port_ctrl #(.WIDTH(4), .DEPTH(4), .CW(3)) dut (
    .clk(clk), .reset(reset),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .in_req(in_req), .InD(InD), .InE(InE), .in_stall(in_stall),
    .OutD(OutD), .out_req(out_req), .out_stall(out_stall),
    .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ext_in_data = 4'h0; ext_in_valid = 1'b0; in_req = 1'b0;
    OutD = 4'h0; out_req = 1'b0; ext_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    #1;
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_vec++; if (InE !== 1'b0) begin n_err++; $display("FAIL reset_ine got %b want 0", InE); end
    n_vec++; if (InD !== 4'h0) begin n_err++; $display("FAIL reset_ind got %h want 0", InD); end
    n_vec++; if (ext_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_oval got %b want 0", ext_out_valid); end
    n_vec++; if (ext_out_data !== 4'h0) begin n_err++; $display("FAIL reset_odata got %h want 0", ext_out_data); end
    n_vec++; if (ext_in_ready !== 1'b1) begin n_err++; $display("FAIL reset_iready got %b want 1", ext_in_ready); end
    n_vec++; if (in_stall !== 1'b0 || out_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b%b want 00", in_stall, out_stall); end
  endtask

  task automatic test_push_pop();
    logic [3:0] vals [3] = '{4'h3, 4'hA, 4'h5};
    for (int i = 0; i < 3; i++) begin
      ext_in_data = vals[i]; ext_in_valid = 1'b1;
      tick();
    end
    ext_in_valid = 1'b0;
    #1;
    n_vec++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL push3_count got %0d want 3", fifo_count); end
    n_vec++; if (ext_in_ready !== 1'b1) begin n_err++; $display("FAIL push3_ready got %b want 1", ext_in_ready); end
    n_vec++; if (InE !== 1'b0) begin n_err++; $display("FAIL push3_ine got %b want 0", InE); end
    in_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) in_req = 1'b0;
      n_vec++; if (InE !== 1'b1 || InD !== vals[i]) begin n_err++; $display("FAIL pop3_%0d got InE=%b InD=%h want 1 %h", i, InE, InD, vals[i]); end
    end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL pop3_count got %0d want 0", fifo_count); end
    tick();
    n_vec++; if (InE !== 1'b0 || InD !== 4'h5) begin n_err++; $display("FAIL pop3_idle got InE=%b InD=%h want 0 5", InE, InD); end
  endtask

  task automatic test_full();
    logic [3:0] vals [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    for (int i = 0; i < 4; i++) begin
      ext_in_data = vals[i]; ext_in_valid = 1'b1;
      tick();
    end
    ext_in_data = 4'h9;
    #1;
    n_vec++; if (ext_in_ready !== 1'b0 || fifo_count !== 3'd4) begin n_err++; $display("FAIL full_state got ready=%b count=%0d want 0 4", ext_in_ready, fifo_count); end
    tick();
    n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_hold got %0d want 4", fifo_count); end
    in_req = 1'b1;
    tick();
    ext_in_valid = 1'b0;
    n_vec++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL full_pop_nopush got %0d want 3", fifo_count); end
    n_vec++; if (InE !== 1'b1 || InD !== 4'h1) begin n_err++; $display("FAIL full_pop_0 got InE=%b InD=%h want 1 1", InE, InD); end
    for (int i = 1; i < 4; i++) begin
      tick();
      if (i == 3) in_req = 1'b0;
      n_vec++; if (InE !== 1'b1 || InD !== vals[i]) begin n_err++; $display("FAIL full_pop_%0d got InE=%b InD=%h want 1 %h", i, InE, InD, vals[i]); end
    end
    n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL full_drain got %0d want 0", fifo_count); end
    tick();
    n_vec++; if (InE !== 1'b0 || fifo_count !== 3'd0) begin n_err++; $display("FAIL full_no9 got InE=%b count=%0d want 0 0", InE, fifo_count); end
  endtask

  task automatic test_stall();
    in_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (in_stall !== 1'b1) begin n_err++; $display("FAIL stall_%0d got %b want 1", i, in_stall); end
      tick();
      n_vec++; if (InE !== 1'b0) begin n_err++; $display("FAIL stall_ine_%0d got %b want 0", i, InE); end
    end
    ext_in_data = 4'h7; ext_in_valid = 1'b1;
    #1;
    n_vec++; if (in_stall !== 1'b1) begin n_err++; $display("FAIL stall_pushcyc got %b want 1", in_stall); end
    tick();
    ext_in_valid = 1'b0;
    #1;
    n_vec++; if (in_stall !== 1'b0 || InE !== 1'b0 || fifo_count !== 3'd1) begin n_err++; $display("FAIL stall_drop got stall=%b InE=%b count=%0d want 0 0 1", in_stall, InE, fifo_count); end
    tick();
    in_req = 1'b0;
    n_vec++; if (InE !== 1'b1 || InD !== 4'h7) begin n_err++; $display("FAIL stall_pop got InE=%b InD=%h want 1 7", InE, InD); end
    tick();
    n_vec++; if (InE !== 1'b0) begin n_err++; $display("FAIL stall_once got %b want 0", InE); end
  endtask

  task automatic test_out_stall();
    ext_out_ready = 1'b0; OutD = 4'hC; out_req = 1'b1;
    #1;
    n_vec++; if (out_stall !== 1'b0) begin n_err++; $display("FAIL out_first_stall got %b want 0", out_stall); end
    tick();
    OutD = 4'hD;
    n_vec++; if (ext_out_valid !== 1'b1 || ext_out_data !== 4'hC) begin n_err++; $display("FAIL out_cap_c got v=%b d=%h want 1 c", ext_out_valid, ext_out_data); end
    #1;
    n_vec++; if (out_stall !== 1'b1) begin n_err++; $display("FAIL out_stall got %b want 1", out_stall); end
    tick();
    n_vec++; if (ext_out_data !== 4'hC || ext_out_valid !== 1'b1 || out_stall !== 1'b1) begin n_err++; $display("FAIL out_hold got d=%h v=%b s=%b want c 1 1", ext_out_data, ext_out_valid, out_stall); end
    ext_out_ready = 1'b1;
    #1;
    n_vec++; if (out_stall !== 1'b0) begin n_err++; $display("FAIL out_unstall got %b want 0", out_stall); end
    tick();
    out_req = 1'b0;
    n_vec++; if (ext_out_valid !== 1'b1 || ext_out_data !== 4'hD) begin n_err++; $display("FAIL out_b2b got v=%b d=%h want 1 d", ext_out_valid, ext_out_data); end
    tick();
    ext_out_ready = 1'b0;
    n_vec++; if (ext_out_valid !== 1'b0 || ext_out_data !== 4'hD) begin n_err++; $display("FAIL out_accept got v=%b d=%h want 0 d", ext_out_valid, ext_out_data); end
  endtask

  task automatic test_back_to_back();
    ext_in_valid = 1'b1;
    ext_in_data = 4'h6; tick();
    ext_in_data = 4'h8; tick();
    ext_in_data = 4'hB; in_req = 1'b1; out_req = 1'b1; OutD = 4'h5;
    tick();
    idle_inputs();
    n_vec++; if (fifo_count !== 3'd2) begin n_err++; $display("FAIL b2b_count got %0d want 2", fifo_count); end
    n_vec++; if (InE !== 1'b1 || InD !== 4'h6) begin n_err++; $display("FAIL b2b_pop got InE=%b InD=%h want 1 6", InE, InD); end
    n_vec++; if (ext_out_valid !== 1'b1 || ext_out_data !== 4'h5) begin n_err++; $display("FAIL b2b_out got v=%b d=%h want 1 5", ext_out_valid, ext_out_data); end
  endtask

  task automatic test_reset_mid();
    ext_in_valid = 1'b1; ext_in_data = 4'h2;
    tick();
    ext_in_data = 4'h4; in_req = 1'b1;
    tick();
    idle_inputs();
    n_vec++; if (fifo_count !== 3'd3 || InE !== 1'b1 || InD !== 4'h8 || ext_out_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset got count=%0d InE=%b InD=%h v=%b want 3 1 8 1", fifo_count, InE, InD, ext_out_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if (fifo_count !== 3'd0 || InE !== 1'b0 || ext_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset got count=%0d InE=%b v=%b want 0 0 0", fifo_count, InE, ext_out_valid); end
    n_vec++; if (ext_in_ready !== 1'b1 || InD !== 4'h0 || ext_out_data !== 4'h0) begin n_err++; $display("FAIL mid_reset_data got ready=%b InD=%h d=%h want 1 0 0", ext_in_ready, InD, ext_out_data); end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full();
    test_stall();
    test_out_stall();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_port_ctrl.md
# io_port_ctrl

External I/O port controller for the 4-bit CPU, sitting on the far side of the register file's input port (InD/InE into R2) and output port (OutD from R3). It buffers nibbles from an external producer in a small FIFO and delivers one per CPU IN request as a single-cycle register-file write strobe. It also captures R3 on each CPU OUT request and presents it to an external consumer over a valid/ready handshake, stalling the CPU when either side cannot proceed.

## Interface
- WIDTH, 4, data width; matches the register width
- DEPTH, 4, input FIFO depth; power of two, at least 2
- CW, 3, count width, equal to clog2(DEPTH+1)

- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- ext_in_data  input  WIDTH  nibble from the external producer
- ext_in_valid  input  1  producer has data
- ext_in_ready  output  1  FIFO can accept; equals (fifo_count != DEPTH), combinational
- in_req  input  1  CPU executing IN; held high until in_stall is low
- InD  output  WIDTH  registered data to the register-file input port
- InE  output  1  registered one-cycle write strobe for R2
- in_stall  output  1  in_req & FIFO empty, combinational
- OutD  input  WIDTH  current R3 value from the register file
- out_req  input  1  CPU executing OUT; held high until out_stall is low
- out_stall  output  1  out_req & ext_out_valid & !ext_out_ready, combinational
- ext_out_data  output  WIDTH  registered nibble to the external consumer
- ext_out_valid  output  1  ext_out_data is valid
- ext_out_ready  input  1  consumer accepts
- fifo_count  output  CW  current FIFO occupancy, 0..DEPTH

## Operation
- Input FIFO: circular buffer with wr_ptr/rd_ptr (log2(DEPTH) bits, natural wrap-around) and count.
- Push when ext_in_valid & ext_in_ready: store at wr_ptr, then increment wr_ptr.
- Pop when in_req & (count != 0): latch mem[rd_ptr] into InD, set InE=1 for the next cycle, then increment rd_ptr.
- InE is cleared on every cycle without a pop. InD holds its last value when InE=0.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: ext_in_ready=0, so no push occurs, even if a pop happens in the same cycle.
- Empty with in_req: in_stall=1 and no pop occurs. A push in that cycle becomes visible on the next cycle, when the pop proceeds.
- Output side: capture is permitted when !ext_out_valid | ext_out_ready.
- On out_req with capture permitted: ext_out_data <= OutD and ext_out_valid <= 1.
- Without out_req, a handshake (valid & ready) clears ext_out_valid.
- While ext_out_valid & !ext_out_ready, ext_out_data is held stable and any out_req is stalled.
- An accepting handshake and a new out_req in the same cycle load the new data back-to-back, with valid staying 1.
- Input and output paths are independent and may be active in the same cycle.

## Timing
- Reset values: wr_ptr=0, rd_ptr=0, fifo_count=0, InD=0, InE=0, ext_out_data=0, ext_out_valid=0. FIFO storage is not cleared.
- Reset mid-operation discards all FIFO contents, any pending InE strobe, and any unaccepted output nibble. Outputs reach their reset values on the cycle after the reset edge.
- IN latency: in_req accepted at edge N, InE=1 and InD valid during cycle N+1, R2 written at edge N+1.
- Input throughput: one pop per cycle when in_req is held high and the FIFO is non-empty.
- Push-to-pop latency: a nibble pushed at edge N can be popped at edge N+1 at the earliest.
- OUT latency: out_req accepted at edge N, ext_out_valid=1 from cycle N+1. OutD is sampled at edge N.
- Output throughput: one nibble per cycle when ext_out_ready is held high.

## Test plan
- Reset, then push 0x3, 0xA, 0x5 with in_req low -> fifo_count=3, ext_in_ready=1, InE=0.
- Fill FIFO with 0x1,0x2,0x3,0x4, then hold ext_in_valid with 0x9 -> ext_in_ready=0, 0x9 is not stored. Pop four times with in_req -> InE pulses on four consecutive cycles with InD 0x1,0x2,0x3,0x4, then fifo_count=0.
- in_req asserted while empty -> in_stall=1 for 3 cycles. Push 0x7 -> in_stall drops one cycle later, then InE=1 with InD=0x7 for exactly one cycle.
- Issue out_req with OutD=0xC while ext_out_ready=0 -> ext_out_valid=1, ext_out_data=0xC. Second out_req with OutD=0xD -> out_stall=1 and data stays 0xC. Raise ready -> 0xD is loaded the next cycle with valid held at 1.
- Issue out_req at the same time as a simultaneous push and pop at count=2 -> count stays 2, InE pulses, and the output captures.
- Assert reset with the FIFO at count=3, InE pending and ext_out_valid=1 -> on the next cycle all of these are 0 and ext_in_ready=1.
